// File: rtl/mem1_read_controller.sv
// MEM1 line-buffer serializer: reads LINES words from a 1-cycle-latency memory and shifts
// each one out MSB-first in a FRAME-bit slot. Optional pad parity: MEM1_READ_PARITY_EN.
module mem1_read_controller #(
  parameter int DWL   = 20,
  parameter int LINES = 20,
  parameter int FRAME = 24,
  parameter int AWL   = 5
) (
  input  logic           iCLK,
  input  logic           iRST,
  input  logic           iCLR,
  input  logic           iSTART,
  input  logic           iEN,
  input  logic [DWL-1:0] iRd_DATA,
  output logic           oRd_EN,
  output logic [AWL-1:0] oRd_ADDR,
  output logic           MISO,
  output logic           oBUSY,
  output logic           oRd_DONE
);

  localparam int CW = $clog2(FRAME + 1);
  localparam logic [CW-1:0]  C_DWL    = CW'(DWL);
  localparam logic [CW-1:0]  C_LASTB  = CW'(DWL - 1);
  localparam logic [CW-1:0]  C_FEND   = CW'(FRAME - 1);
  localparam logic [AWL-1:0] L_LAST   = AWL'(LINES - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOAD, S_SHIFT} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [AWL-1:0] line;
  logic [DWL-1:0] sr, hold;
  logic           pend;
  logic           kill, go, adv, frame_end, last_line, pf_trig;

  assign kill  = iRST | iCLR;
  assign oBUSY = (state != S_IDLE);

  always_ff @(posedge iCLK) begin
    if (kill) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    adv       = 1'b0;
    frame_end = 1'b0;
    pf_trig   = 1'b0;
    last_line = (line == L_LAST);
    case (state)
      S_IDLE:  if (iSTART) begin
                 go        = 1'b1;
                 state_nxt = S_FETCH;
               end
      S_FETCH: state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_SHIFT;
      S_SHIFT: if (iEN) begin
                 adv       = 1'b1;
                 frame_end = (cnt == C_FEND);
                 pf_trig   = (cnt == C_LASTB) && !last_line;
                 if (frame_end && last_line) state_nxt = S_IDLE;
               end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Read data is valid the cycle after the strobe, i.e. once the strobe has dropped.
  always_ff @(posedge iCLK) begin
    if (kill) begin
      cnt      <= '0;
      line     <= '0;
      sr       <= '0;
      hold     <= '0;
      pend     <= 1'b0;
      oRd_EN   <= 1'b0;
      oRd_ADDR <= '0;
      oRd_DONE <= 1'b0;
    end else begin
      oRd_EN   <= go | pf_trig;
      oRd_DONE <= adv && frame_end && last_line;
      if (go) begin
        oRd_ADDR <= '0;
        line     <= '0;
      end
      if (pend && !oRd_EN) begin
        hold <= iRd_DATA;
        pend <= 1'b0;
      end
      if (pf_trig) begin
        oRd_ADDR <= line + 1'b1;
        pend     <= 1'b1;
      end
      if (state == S_LOAD) begin
        sr  <= iRd_DATA;
        cnt <= '0;
      end
      if (adv) begin
        if (frame_end) begin
          cnt <= '0;
          if (!last_line) begin
            sr   <= hold;
            line <= line + 1'b1;
          end
        end else begin
          cnt <= cnt + 1'b1;
          if (cnt < C_DWL) sr <= {sr[DWL-2:0], 1'b0};
        end
      end
    end
  end

`ifdef MEM1_READ_PARITY_EN
  // Even parity of the line currently being shifted, captured whenever sr is loaded.
  logic par;

  always_ff @(posedge iCLK) begin
    if (kill)                                  par <= 1'b0;
    else if (state == S_LOAD)                  par <= ^iRd_DATA;
    else if (adv && frame_end && !last_line)   par <= ^hold;
  end

  assign MISO = (state == S_SHIFT) &&
                ((cnt < C_DWL) ? sr[DWL-1] : ((cnt == C_DWL) && par));
`else
  assign MISO = (state == S_SHIFT) && (cnt < C_DWL) && sr[DWL-1];
`endif

endmodule

// File: tb/tb_mem1_read_controller.sv
// Scoreboard bench for mem1_read_controller: expected bits/strobes queued per image,
// a negedge monitor pops and compares.
module tb_mem1_read_controller;
  localparam int DWL = 20, LINES = 20, FRAME = 24, AWL = 5;

  logic           iCLK = 0, iRST = 1, iCLR = 0, iSTART = 0, iEN = 0;
  logic [DWL-1:0] iRd_DATA;
  logic           oRd_EN, MISO, oBUSY, oRd_DONE;
  logic [AWL-1:0] oRd_ADDR;

  logic [DWL-1:0] mem [LINES];
  bit             bitq[$];
  int             addrq[$];
  int             checks = 0, errors = 0, done_cnt = 0;
  int             busy_n = 0, slot = 0;
  logic           prev_en = 0, prev_s19 = 0;

  mem1_read_controller #(.DWL(DWL), .LINES(LINES), .FRAME(FRAME), .AWL(AWL)) dut (
    .iCLK(iCLK), .iRST(iRST), .iCLR(iCLR), .iSTART(iSTART), .iEN(iEN),
    .iRd_DATA(iRd_DATA), .oRd_EN(oRd_EN), .oRd_ADDR(oRd_ADDR), .MISO(MISO),
    .oBUSY(oBUSY), .oRd_DONE(oRd_DONE)
  );

  always #5 iCLK = ~iCLK;

  always @(posedge iCLK) if (oRd_EN) iRd_DATA <= mem[oRd_ADDR];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: every line is DWL data bits MSB-first, then a pad slot that is parity or 0.
  task automatic push_image();
    bit pbit;
    for (int k = 0; k < LINES; k++) begin
      addrq.push_back(k);
      for (int b = 0; b < FRAME; b++) begin
`ifdef MEM1_READ_PARITY_EN
        pbit = (b == DWL) ? ^mem[k] : 1'b0;
`else
        pbit = 1'b0;
`endif
        bitq.push_back(b < DWL ? mem[k][DWL-1-b] : pbit);
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rd_en"}, oRd_EN, 0);
    chk({tag, "_rd_addr"}, oRd_ADDR, 0);
    chk({tag, "_miso"}, MISO, 0);
    chk({tag, "_busy"}, oBUSY, 0);
    chk({tag, "_done"}, oRd_DONE, 0);
  endtask

  function automatic logic pick_en(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 3) == 0;
      default: return 1'($urandom % 2);
    endcase
  endfunction

  // mode 0: iEN constant, 1: one-of-three, 2: random. restart_at/abort_at are slot indices, -1 = off.
  task automatic run_image(input int mode, input int restart_at, input int abort_at);
    int s = 0, cyc = 0, d0;
    logic en;
    push_image();
    d0 = done_cnt;
    @(posedge iCLK); #1 iSTART = 1;
    @(posedge iCLK); #1 iSTART = 0; iEN = 1'($urandom % 2);
    @(posedge iCLK); #1 iEN = 1'($urandom % 2);
    while (s < LINES * FRAME && cyc < 20000) begin
      @(posedge iCLK); #1;
      if (s == abort_at) begin
        iEN = 0; iSTART = 0; iRST = 1;
        bitq.delete(); addrq.delete();
        @(posedge iCLK); #1 iRST = 0;
        check_idle_outputs("abort");
        chk("abort_no_done", done_cnt, d0);
        return;
      end
      iSTART = (s == restart_at);
      en = pick_en(mode, cyc);
      iEN = en;
      if (en) s++;
      cyc++;
    end
    chk("image_slots", s, LINES * FRAME);
    @(posedge iCLK); #1 iEN = 0; iSTART = 0;
    @(posedge iCLK); #1;
    chk("done_once", done_cnt, d0 + 1);
    chk("bits_left", bitq.size(), 0);
    chk("strobes_left", addrq.size(), 0);
    chk("idle_busy", oBUSY, 0);
  endtask

  always @(negedge iCLK) begin
    if (oRd_DONE) begin
      chk("done_slot", slot, LINES * FRAME);
      chk("done_busy", oBUSY, 0);
      done_cnt++;
    end
    busy_n = oBUSY ? busy_n + 1 : 0;
    if (busy_n == 1) slot = 0;
    if (oRd_EN) begin
      if (addrq.size() == 0) begin
        checks++; errors++;
        $display("FAIL strobe unexpected addr %0d at %0t", oRd_ADDR, $time);
      end else chk("rd_addr", oRd_ADDR, addrq.pop_front());
      chk("strobe_width", prev_en, 0);
      chk("strobe_slot", ((busy_n == 1) || prev_s19) ? 1 : 0, 1);
    end
    prev_en  = oRd_EN;
    prev_s19 = 0;
    if (busy_n >= 3 && iEN && !iRST && !iCLR) begin
      if (bitq.size() == 0) begin
        checks++; errors++;
        $display("FAIL miso unexpected slot %0d at %0t", slot, $time);
      end else chk("miso", MISO, bitq.pop_front());
      prev_s19 = ((slot % FRAME) == DWL - 1) && (slot < (LINES - 1) * FRAME);
      slot++;
    end
  end

  initial begin
    for (int k = 0; k < LINES; k++) mem[k] = 20'h5A5A0 | DWL'(k);
    repeat (3) @(posedge iCLK);
    #1 check_idle_outputs("reset");
    iRST = 0;

    run_image(0, -1, -1);
    run_image(1, -1, -1);
    run_image(2, 5 * FRAME + 7, -1);
    run_image(0, -1, 7 * FRAME + 12);
    run_image(2, -1, -1);

    @(posedge iCLK); #1 iCLR = 1; iSTART = 1;
    @(posedge iCLK); #1 iCLR = 0; iSTART = 0;
    chk("clr_start_rd_en", oRd_EN, 0);
    chk("clr_start_busy", oBUSY, 0);
    @(posedge iCLK); #1;
    chk("clr_start_busy2", oBUSY, 0);
    chk("clr_start_rd_en2", oRd_EN, 0);

    for (int k = 0; k < LINES; k++) mem[k] = DWL'($urandom);
    mem[3] = 20'h00007;
    run_image(2, -1, -1);
    run_image(0, -1, -1);

    repeat (3) @(posedge iCLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
